mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Next-generation memory stage of the 5-stage core, replacing the combinational EX->WB pass-through. It accepts one instruction per handshake from EX. ALU results are forwarded to WB after one register stage. Loads and stores are issued on a req/ack data-memory bus, and EX is stalled until the bus acknowledges. Load data is lane-aligned and sign- or zero-extended before it reaches the writeback register.

Parameters:
XLEN, 64, datapath and register width; legal values 32 or 64.
AW, 32, data-memory byte-address width.
NB, XLEN/8, bytes per bus beat (derived; do not override).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
ex_valid  in  1  EX presents an instruction
ex_ready  out  1  stage can accept (handshake = ex_valid & ex_ready)
ex_op  in  4  0=ALU, 1=LB, 2=LH, 3=LW, 4=LD, 5=LBU, 6=LHU, 7=LWU, 8=SB, 9=SH, 10=SW, 11=SD; others = ALU
ex_addr  in  AW  effective address (load/store)
ex_data  in  XLEN  ALU result (ALU op) or store data (store)
ex_w_ena  in  1  register write enable
ex_w_addr  in  5  destination register
mem_req  out  1  bus request, held until ack
mem_we  out  1  1=store
mem_addr  out  AW  word-aligned address (low log2(NB) bits zero)
mem_wdata  out  XLEN  store data shifted to byte lane
mem_wstrb  out  NB  byte enables
mem_ack  in  1  bus completes request this cycle; mem_rdata valid with it
mem_rdata  in  XLEN  read beat
wb_valid  out  1  one-cycle pulse, writeback result valid
wb_data  out  XLEN  writeback data
wb_w_ena  out  1  register write enable (0 for stores, 0 when w_addr==0)
wb_w_addr  out  5  destination register

Behaviour:
- Reset: all outputs 0, FSM = IDLE; ex_ready = 0 during reset and 1 in the cycle after reset deasserts.
- FSM states: IDLE, BUSY.
- IDLE: ex_ready=1.
  - Handshake with an ALU op: the next cycle has wb_valid=1, wb_data=ex_data, wb_w_ena=ex_w_ena & (ex_w_addr!=0), wb_w_addr=ex_w_addr. Latency 1; throughput 1 per cycle.
  - Handshake with a load/store: latch op, address, data and rd into internal registers, then go to BUSY. mem_req=1 from the next cycle.
- BUSY: ex_ready=0, and mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb stay constant.
  - On mem_ack: go to IDLE. The next cycle has wb_valid=1.
  - The earliest next acceptance is the cycle after ack, so a one-cycle-ack memory completes a load/store in 2 cycles plus a 1-cycle WB register.
  - mem_ack while in IDLE is ignored.
- wb_valid is 0 in every cycle not listed above. WB never stalls.
- Lane alignment: off = ex_addr[log2(NB)-1:0].
  - mem_wstrb = size mask (1, 3, F, FF) << off.
  - mem_wdata = (store data low bytes) << (8*off).
- Load extraction: (mem_rdata >> 8*off), truncated to access size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU/LD) to XLEN.
- Stores produce wb_valid=1 with wb_w_ena=0, wb_data=0, so retire counting stays uniform.
- XLEN=32: LD, LWU and SD are treated as LW, LW and SW respectively.
- Accesses that cross a beat boundary are not split; bytes beyond the beat are dropped (see optional feature).
- rst mid-BUSY: mem_req drops the next cycle, the transaction is abandoned, and no wb_valid is produced. The bus must tolerate request withdrawal on reset.

Optional Feature:
MEM_STAGE_MISALIGN_CHK_EN.
- Defined: adds output port wb_misalign (1 bit). A load/store whose address is not naturally aligned to its size (off % size != 0) never enters BUSY and never asserts mem_req. The next cycle has wb_valid=1, wb_misalign=1, wb_w_ena=0 and wb_data = the zero-extended address.
- Undefined: port absent; misaligned accesses are issued as described above.

Test Plan:
- ALU pass: rst 2 cycles, then ex_op=0, ex_data=0x1234, ex_w_addr=5, ex_w_ena=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_w_ena=1, wb_w_addr=5; back-to-back ALU ops each retire 1 cycle later with no bubbles.
- Load sign/zero extend: XLEN=64, LB at addr 0x1003, ack after 3 cycles with rdata 0x00000000_80000000 -> mem_addr=0x1000, wb_data=0xFFFF_FFFF_FFFF_FF80; the same access as LBU -> wb_data=0x80.
- Store lanes: SH at 0x2006, ex_data=0xABCD -> mem_we=1, mem_wstrb=0xC0, mem_wdata=0xABCD_0000_0000_0000; then wb_valid=1 with wb_w_ena=0.
- Stall hold: load with ack delayed 5 cycles while ex_valid is held -> ex_ready=0 and mem_* stable for all 5 cycles; second instruction accepted the cycle after ack.
- x0 write and reset mid-op: ALU op to rd=0 -> wb_w_ena=0. rst asserted in the 2nd BUSY cycle -> mem_req=0 next cycle, no wb_valid, ack afterwards ignored.
- MEM_STAGE_MISALIGN_CHK_EN: LW at 0x1002 -> mem_req never 1; next cycle wb_valid=1, wb_misalign=1, wb_data=0x1002.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage of the 5-stage core.
// ALU results reach WB after one register stage; loads/stores are issued on a
// req/ack data-memory bus while EX is held off, and load data is lane-aligned
// and sign/zero-extended before it reaches the writeback register.
// Optional feature macro: MEM_STAGE_MISALIGN_CHK_EN (adds wb_misalign and
// retires misaligned loads/stores without touching the bus).
module mem_stage_lsu #(
    parameter int XLEN = 64,
    parameter int AW   = 32,
    parameter int NB   = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [3:0]      ex_op,
    input  logic [AW-1:0]   ex_addr,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_w_ena,
    input  logic [4:0]      ex_w_addr,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [NB-1:0]   mem_wstrb,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_w_ena,
    output logic [4:0]      wb_w_addr
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    ,
    output logic            wb_misalign
`endif
);

    localparam int OB = $clog2(NB);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Fold 64-bit-only ops onto their 32-bit equivalents and map unused codes to ALU.
    function automatic logic [3:0] norm_op(input logic [3:0] op);
        logic [3:0] r;
        case (op)
            4'd4:    r = (XLEN == 32) ? 4'd3  : 4'd4;
            4'd7:    r = (XLEN == 32) ? 4'd3  : 4'd7;
            4'd11:   r = (XLEN == 32) ? 4'd10 : 4'd11;
            4'd12, 4'd13, 4'd14, 4'd15: r = 4'd0;
            default: r = op;
        endcase
        return r;
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd11);
    endfunction

    function automatic logic is_signed_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd3);
    endfunction

    // Access size in bytes.
    function automatic logic [3:0] op_size(input logic [3:0] op);
        logic [3:0] r;
        case (op)
            4'd1, 4'd5, 4'd8:  r = 4'd1;
            4'd2, 4'd6, 4'd9:  r = 4'd2;
            4'd3, 4'd7, 4'd10: r = 4'd4;
            4'd4, 4'd11:       r = 4'd8;
            default:           r = 4'd1;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] byte_mask8(input logic [3:0] size);
        logic [7:0] r;
        case (size)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h03;
            4'd4:    r = 8'h0F;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] bit_mask(input logic [3:0] size);
        logic [XLEN-1:0] r;
        case (size)
            4'd1:    r = XLEN'(64'h0000_0000_0000_00FF);
            4'd2:    r = XLEN'(64'h0000_0000_0000_FFFF);
            4'd4:    r = XLEN'(64'h0000_0000_FFFF_FFFF);
            default: r = {XLEN{1'b1}};
        endcase
        return r;
    endfunction

    function automatic logic sign_bit(input logic [XLEN-1:0] d, input logic [3:0] size);
        logic r;
        case (size)
            4'd1:    r = d[7];
            4'd2:    r = d[15];
            4'd4:    r = d[31];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic            ex_ready_q, ex_ready_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_w_ena_q, wb_w_ena_d;
    logic [4:0]      wb_w_addr_q, wb_w_addr_d;
    logic [3:0]      op_q, op_d;
    logic [OB-1:0]   off_q, off_d;
    logic            w_ena_q, w_ena_d;
    logic [4:0]      w_addr_q, w_addr_d;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    logic            wb_misalign_q, wb_misalign_d;
    logic            misal_s;
`endif

    logic [3:0]      ex_op_n_s;
    logic [3:0]      ex_size_s;
    logic [OB-1:0]   ex_off_s;
    logic            ex_ls_s;
    logic            ex_issue_s;
    logic            hs_s;
    logic [3:0]      size_q_s;
    logic [XLEN-1:0] rd_sh_s;
    logic [XLEN-1:0] rd_mask_s;
    logic            rd_sgn_s;
    logic [XLEN-1:0] ld_val_s;

    // Decode the incoming instruction and extract the pending load result.
    always_comb begin
        ex_op_n_s = norm_op(ex_op);
        ex_size_s = op_size(ex_op_n_s);
        ex_off_s  = ex_addr[OB-1:0];
        ex_ls_s   = is_load(ex_op_n_s) || is_store(ex_op_n_s);
        hs_s      = ex_valid && ex_ready_q;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        misal_s    = ((4'(ex_off_s) & (ex_size_s - 4'd1)) != 4'd0);
        ex_issue_s = ex_ls_s && !misal_s;
`else
        ex_issue_s = ex_ls_s;
`endif
        size_q_s  = op_size(op_q);
        rd_sh_s   = mem_rdata >> {off_q, 3'b000};
        rd_mask_s = bit_mask(size_q_s);
        rd_sgn_s  = is_signed_load(op_q) && sign_bit(rd_sh_s, size_q_s);
        ld_val_s  = (rd_sh_s & rd_mask_s) | (rd_sgn_s ? ~rd_mask_s : {XLEN{1'b0}});
    end

    // Next-state logic: enter BUSY on an issued load/store, leave on ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs_s && ex_issue_s) begin
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: bus request setup, hold while busy, WB result.
    always_comb begin
        ex_ready_d  = (state_d == IDLE);
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        op_d        = op_q;
        off_d       = off_q;
        w_ena_d     = w_ena_q;
        w_addr_d    = w_addr_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = {XLEN{1'b0}};
        wb_w_ena_d  = 1'b0;
        wb_w_addr_d = 5'd0;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        wb_misalign_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    if (ex_issue_s) begin
                        op_d        = ex_op_n_s;
                        off_d       = ex_off_s;
                        w_ena_d     = ex_w_ena && (ex_w_addr != 5'd0) && is_load(ex_op_n_s);
                        w_addr_d    = ex_w_addr;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(ex_op_n_s);
                        mem_addr_d  = ex_addr & ~(AW'(NB - 1));
                        mem_wdata_d = (ex_data & bit_mask(ex_size_s)) << {ex_off_s, 3'b000};
                        mem_wstrb_d = NB'(byte_mask8(ex_size_s)) << ex_off_s;
                    end
`ifdef MEM_STAGE_MISALIGN_CHK_EN
                    else if (ex_ls_s) begin
                        // Misaligned access retires immediately, reporting its address.
                        mem_req_d     = 1'b0;
                        wb_valid_d    = 1'b1;
                        wb_data_d     = XLEN'(ex_addr);
                        wb_w_addr_d   = ex_w_addr;
                        wb_misalign_d = 1'b1;
                    end
`endif
                    else begin
                        mem_req_d   = 1'b0;
                        wb_valid_d  = 1'b1;
                        wb_data_d   = ex_data;
                        wb_w_ena_d  = ex_w_ena && (ex_w_addr != 5'd0);
                        wb_w_addr_d = ex_w_addr;
                    end
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_w_addr_d = w_addr_q;
                    if (is_store(op_q)) begin
                        wb_data_d  = {XLEN{1'b0}};
                        wb_w_ena_d = 1'b0;
                    end else begin
                        wb_data_d  = ld_val_s;
                        wb_w_ena_d = w_ena_q;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ex_ready_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {XLEN{1'b0}};
            mem_wstrb_q <= {NB{1'b0}};
            op_q        <= 4'd0;
            off_q       <= {OB{1'b0}};
            w_ena_q     <= 1'b0;
            w_addr_q    <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= {XLEN{1'b0}};
            wb_w_ena_q  <= 1'b0;
            wb_w_addr_q <= 5'd0;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
            wb_misalign_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ex_ready_q  <= ex_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            op_q        <= op_d;
            off_q       <= off_d;
            w_ena_q     <= w_ena_d;
            w_addr_q    <= w_addr_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_w_ena_q  <= wb_w_ena_d;
            wb_w_addr_q <= wb_w_addr_d;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
            wb_misalign_q <= wb_misalign_d;
`endif
        end
    end

    assign ex_ready  = ex_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_w_ena  = wb_w_ena_q;
    assign wb_w_addr = wb_w_addr_q;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    assign wb_misalign = wb_misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (XLEN=64, AW=32).
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr;
    logic [63:0] ex_data;
    logic        ex_w_ena;
    logic [4:0]  ex_w_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic        wb_w_ena;
    logic [4:0]  wb_w_addr;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    logic        wb_misalign;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage_lsu #(.XLEN(64), .AW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_addr   (ex_addr),
        .ex_data   (ex_data),
        .ex_w_ena  (ex_w_ena),
        .ex_w_addr (ex_w_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_w_ena  (wb_w_ena),
        .wb_w_addr (wb_w_addr)
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        ,
        .wb_misalign (wb_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; ex_op = 4'd0; ex_addr = 32'd0; ex_data = 64'd0;
        ex_w_ena = 1'b0; ex_w_addr = 5'd0; mem_ack = 1'b0; mem_rdata = 64'd0;
        tick(); tick();
        n_cmp++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", ex_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", mem_req); end
        n_cmp++; if (wb_valid !== 1'b0 || wb_data !== 64'd0) begin n_fail++; $display("FAIL rst_wb got %b/%h exp 0/0", wb_valid, wb_data); end
        rst = 1'b0;
        tick();
        n_cmp++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b exp 1", ex_ready); end
    endtask

    task automatic test_alu();
        ex_valid = 1'b1; ex_op = 4'd0; ex_data = 64'h1234; ex_w_addr = 5'd5; ex_w_ena = 1'b1;
        tick();
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'h1234 || wb_w_ena !== 1'b1 || wb_w_addr !== 5'd5) begin
            n_fail++; $display("FAIL alu_pass got v=%b d=%h e=%b a=%0d exp 1 1234 1 5", wb_valid, wb_data, wb_w_ena, wb_w_addr);
        end
        // back-to-back ALU ops, one retire per cycle
        for (int i = 0; i < 4; i++) begin
            ex_op = 4'(12 + (i % 2) * 3);   // 12 and 15 are ALU aliases too
            ex_op = (i < 2) ? 4'd0 : ex_op;
            ex_data = 64'hA000_0000_0000_0000 + 64'(i);
            ex_w_addr = 5'(i + 1);
            tick();
            n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'hA000_0000_0000_0000 + 64'(i) || wb_w_addr !== 5'(i + 1) || ex_ready !== 1'b1) begin
                n_fail++; $display("FAIL alu_b2b[%0d] got v=%b d=%h a=%0d r=%b", i, wb_valid, wb_data, wb_w_addr, ex_ready);
            end
        end
        ex_op = 4'd0; ex_w_addr = 5'd0; ex_data = 64'h77;
        tick();
        n_cmp++; if (wb_valid !== 1'b1 || wb_w_ena !== 1'b0) begin n_fail++; $display("FAIL alu_x0 got v=%b e=%b exp 1 0", wb_valid, wb_w_ena); end
        ex_valid = 1'b0;
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_idle got %b exp 0", wb_valid); end
    endtask

    task automatic test_load_ext();
        logic [3:0]  ops [7] = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4};
        logic [31:0] adr [7] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1004, 32'h1004, 32'h1008};
        logic [63:0] rdt [7] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                                64'h0000_0000_8001_0000, 64'h0000_0000_8001_0000,
                                64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000,
                                64'h8123_4567_89AB_CDEF};
        logic [63:0] exp [7] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080,
                                64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001,
                                64'hFFFF_FFFF_F000_0000, 64'h0000_0000_F000_0000,
                                64'h8123_4567_89AB_CDEF};
        logic [31:0] ea  [7] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1008};
        for (int i = 0; i < 7; i++) begin
            ex_valid = 1'b1; ex_op = ops[i]; ex_addr = adr[i]; ex_data = 64'hDEAD;
            ex_w_ena = 1'b1; ex_w_addr = 5'(10 + i);
            tick();
            ex_valid = 1'b0;
            n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea[i] || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL ld_issue[%0d] got req=%b we=%b a=%h r=%b v=%b exp 1 0 %h 0 0", i, mem_req, mem_we, mem_addr, ex_ready, wb_valid, ea[i]);
            end
            if (i == 0) begin
                tick(); tick();
            end
            mem_ack = 1'b1; mem_rdata = rdt[i];
            tick();
            mem_ack = 1'b0; mem_rdata = 64'd0;
            n_cmp++; if (wb_valid !== 1'b1 || wb_data !== exp[i] || wb_w_ena !== 1'b1 || wb_w_addr !== 5'(10 + i)) begin
                n_fail++; $display("FAIL ld_data[%0d] got v=%b d=%h e=%b a=%0d exp d=%h", i, wb_valid, wb_data, wb_w_ena, wb_w_addr, exp[i]);
            end
            n_cmp++; if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin
                n_fail++; $display("FAIL ld_done[%0d] got req=%b r=%b exp 0 1", i, mem_req, ex_ready);
            end
        end
    endtask

    task automatic test_store();
        logic [3:0]  ops [5] = '{4'd9, 4'd8, 4'd10, 4'd11, 4'd10};
        logic [31:0] adr [5] = '{32'h2006, 32'h2001, 32'h2004, 32'h2000, 32'h2006};
        logic [63:0] dat [5] = '{64'hABCD, 64'h1122_3344, 64'hDEAD_BEEF_CAFE_F00D, 64'h0102_0304_0506_0708, 64'hCAFE_F00D};
        logic [7:0]  stb [5] = '{8'hC0, 8'h02, 8'hF0, 8'hFF, 8'hC0};
        logic [63:0] wd  [5] = '{64'hABCD_0000_0000_0000, 64'h0000_0000_0000_4400,
                                64'hCAFE_F00D_0000_0000, 64'h0102_0304_0506_0708,
                                64'hF00D_0000_0000_0000};
        for (int i = 0; i < 5; i++) begin
            ex_valid = 1'b1; ex_op = ops[i]; ex_addr = adr[i]; ex_data = dat[i];
            ex_w_ena = 1'b1; ex_w_addr = 5'd7;
            tick();
            ex_valid = 1'b0;
            n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_wstrb !== stb[i] || mem_wdata !== wd[i]) begin
                n_fail++; $display("FAIL st_lane[%0d] got req=%b we=%b a=%h s=%h d=%h exp s=%h d=%h", i, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, stb[i], wd[i]);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            n_cmp++; if (wb_valid !== 1'b1 || wb_w_ena !== 1'b0 || wb_data !== 64'd0) begin
                n_fail++; $display("FAIL st_wb[%0d] got v=%b e=%b d=%h exp 1 0 0", i, wb_valid, wb_w_ena, wb_data);
            end
        end
    endtask

    task automatic test_stall_hold();
        ex_valid = 1'b1; ex_op = 4'd3; ex_addr = 32'h3004; ex_data = 64'd0; ex_w_ena = 1'b1; ex_w_addr = 5'd4;
        tick();
        // EX now presents the next instruction and keeps it valid
        ex_op = 4'd0; ex_data = 64'h55; ex_w_addr = 5'd9;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) tick();
            n_cmp++; if (ex_ready !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h3000 || wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d] got r=%b req=%b we=%b a=%h v=%b", c, ex_ready, mem_req, mem_we, mem_addr, wb_valid);
            end
        end
        mem_ack = 1'b1; mem_rdata = 64'h1234_5678_0000_0000;
        tick();
        mem_ack = 1'b0; mem_rdata = 64'd0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'h1234_5678 || wb_w_addr !== 5'd4 || ex_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_ack got v=%b d=%h a=%0d r=%b exp 1 12345678 4 1", wb_valid, wb_data, wb_w_addr, ex_ready);
        end
        tick();
        ex_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'h55 || wb_w_addr !== 5'd9) begin
            n_fail++; $display("FAIL stall_next got v=%b d=%h a=%0d exp 1 55 9", wb_valid, wb_data, wb_w_addr);
        end
    endtask

    task automatic test_reset_mid();
        ex_valid = 1'b1; ex_op = 4'd4; ex_addr = 32'h4000; ex_w_ena = 1'b1; ex_w_addr = 5'd3;
        tick();
        ex_valid = 1'b0;
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got %b exp 1", mem_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_drop got req=%b v=%b r=%b exp 0 0 0", mem_req, wb_valid, ex_ready);
        end
        mem_ack = 1'b1; mem_rdata = 64'hFFFF;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0 || mem_req !== 1'b0 || ex_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ack_ignored got v=%b req=%b r=%b exp 0 0 1", wb_valid, mem_req, ex_ready);
        end
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got %b exp 0", wb_valid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_store();
        test_stall_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
